// File: rtl/mem_pkg.sv
// Shared helpers for the mem_array storage block: address width derivation,
// reset data value and the address range check.
package mem_pkg;

    // Value every storage bit and the read register take on reset.
    localparam logic RST_BIT = 1'b0;

    // Address bits needed to index n words (at least one bit).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // True when address a selects a word that physically exists.
    function automatic logic addr_ok(input int unsigned a, input int unsigned depth);
        return a < depth;
    endfunction

endpackage

// File: rtl/mem_word.sv
// One storage word: WIDTH-bit register with write enable and async clear.
module mem_word
    import mem_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when selected; clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= {WIDTH{RST_BIT}};
        else if (we)
            q <= d;
    end

endmodule

// File: rtl/mem_array.sv
// DEPTH x WIDTH synchronous memory with chip select, write-first same-address
// bypass, registered read data, read-valid pulse and out-of-range flag.
module mem_array
    import mem_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CS,
    input  logic             R,
    input  logic             W,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] O,
    output logic             VLD,
    output logic             ERR
);

    logic [DEPTH-1:0][WIDTH-1:0] words;
    logic                        in_rng;
    logic                        wr_en;
    logic                        rd_en;
    logic                        oor_acc;
    logic [WIDTH-1:0]            rd_mux;
    logic [WIDTH-1:0]            rd_data;

    assign in_rng  = addr_ok(32'(A), DEPTH);
    assign wr_en   = CS & W & in_rng;
    assign rd_en   = CS & R;
    assign oor_acc = CS & (R | W) & ~in_rng;

    // Storage: one register per word, enabled by the decoded address.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        mem_word #(.WIDTH(WIDTH)) u_word (
            .clk (CLK),
            .rst (RST),
            .we  (wr_en && (A == AW'(i))),
            .d   (D),
            .q   (words[i])
        );
    end

    // Read mux; an address with no backing word reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < DEPTH; i++)
            if (A == AW'(i))
                rd_mux = words[i];
    end

    // Write-first: a same-edge write to the read address returns the new data.
    always_comb begin
        rd_data = wr_en ? D : rd_mux;
    end

    // Output registers: O holds between reads, VLD/ERR are single-cycle pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O   <= {WIDTH{RST_BIT}};
            VLD <= 1'b0;
            ERR <= 1'b0;
        end else begin
            if (rd_en)
                O <= rd_data;
            VLD <= rd_en;
            ERR <= oor_acc;
        end
    end

endmodule

// File: tb/tb_mem_array.sv
// Randomised and directed check of mem_array (WIDTH=16, DEPTH=12) against a
// behavioural model of the memory's access rules.
module tb_mem_array;

    localparam int WIDTH = 16;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic             CLK;
    logic             RST;
    logic             CS;
    logic             R;
    logic             W;
    logic [AW-1:0]    A;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] O;
    logic             VLD;
    logic             ERR;

    int n_cmp;
    int n_bad;

    // Behavioural model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_o;
    logic             m_vld;
    logic             m_err;

    mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .CS  (CS),
        .R   (R),
        .W   (W),
        .A   (A),
        .D   (D),
        .O   (O),
        .VLD (VLD),
        .ERR (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_o   = '0;
        m_vld = 1'b0;
        m_err = 1'b0;
    endfunction

    // Apply one access at the next rising edge and advance the model.
    task automatic cyc(input logic cs, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bit oor;
        @(negedge CLK);
        CS = cs; R = r; W = w; A = a; D = d;
        @(posedge CLK);
        if (RST) begin
            model_clear();
        end else if (!cs) begin
            m_vld = 1'b0;
            m_err = 1'b0;
        end else begin
            oor   = (int'(a) >= DEPTH);
            m_err = (r | w) & oor;
            if (w && !oor) m_mem[a] = d;
            m_vld = r;
            if (r) m_o = oor ? '0 : m_mem[a];
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, AW'(i), '0);
    endtask

    // Every cycle, outputs must match the model.
    always @(negedge CLK) begin
        chk("O",   32'(O),   32'(m_o));
        chk("VLD", 32'(VLD), 32'(m_vld));
        chk("ERR", 32'(ERR), 32'(m_err));
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_clear();
        RST = 1'b1; CS = 1'b0; R = 1'b0; W = 1'b0; A = '0; D = '0;
        #22;
        chk("reset_O", 32'(O), 32'h0);
        chk("reset_VLD", 32'(VLD), 32'h0);
        RST = 1'b0;

        // Reset contents read back as zero
        read_all();
        chk("pin_rd_zero_O", 32'(O), 32'h0);
        chk("pin_rd_zero_VLD", 32'(VLD), 32'h1);

        // Write then read the next cycle; neighbour untouched
        cyc(1'b1, 1'b0, 1'b1, 4'd3, 16'hA5A5);
        chk("pin_wr_no_vld", 32'(VLD), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 16'h0000);
        chk("pin_rd3_O", 32'(O), 32'hA5A5);
        chk("pin_rd3_model", 32'(m_o), 32'hA5A5);
        chk("pin_rd3_VLD", 32'(VLD), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 4'd4, 16'h0000);
        chk("pin_rd4_O", 32'(O), 32'h0);

        // Same-edge read and write: new data returned
        cyc(1'b1, 1'b0, 1'b1, 4'd7, 16'hFFFF);
        cyc(1'b1, 1'b1, 1'b1, 4'd7, 16'h1234);
        chk("pin_rw7_O", 32'(O), 32'h1234);
        idle();
        cyc(1'b1, 1'b1, 1'b0, 4'd7, 16'h0000);
        chk("pin_rd7_O", 32'(O), 32'h1234);

        // Out-of-range write then read
        cyc(1'b1, 1'b0, 1'b1, 4'd13, 16'hBEEF);
        chk("pin_oor_wr_ERR", 32'(ERR), 32'h1);
        chk("pin_oor_wr_VLD", 32'(VLD), 32'h0);
        idle();
        chk("pin_err_pulse", 32'(ERR), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 4'd13, 16'h0000);
        chk("pin_oor_rd_ERR", 32'(ERR), 32'h1);
        chk("pin_oor_rd_O", 32'(O), 32'h0);
        chk("pin_oor_rd_VLD", 32'(VLD), 32'h1);
        read_all();

        // Chip select low blocks everything
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 4'd2, 16'h5555);
        chk("pin_cs0_O", 32'(O), 32'hA5A5);
        chk("pin_cs0_VLD", 32'(VLD), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 4'd2, 16'h0000);
        chk("pin_cs0_mem2", 32'(O), 32'h0);

        // Async reset in the middle of a write burst
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, AW'(i), 16'(16'h1111 * (i + 1)));
        chk("pin_pre_rst_O", 32'(O), 32'h6666);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_O", 32'(O), 32'h0);
        chk("async_rst_VLD", 32'(VLD), 32'h0);
        chk("async_rst_ERR", 32'(ERR), 32'h0);
        model_clear();
        cyc(1'b1, 1'b1, 1'b1, 4'd8, 16'hDEAD);
        #2;
        RST = 1'b0;
        read_all();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                AW'($urandom_range(0, 15)), WIDTH'($urandom));
        end
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
